vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter MAP_W, default 80, tile-map width in tiles (640/8).
REQ-002 Parameter MAP_H, default 60, tile-map height in tiles (480/8).
REQ-003 Parameter FIFO_DEPTH, default 4, number of write-queue entries; power of two.
REQ-004 clk  in  1  system clock (50 MHz).
REQ-005 reset  in  1  reset, synchronous, active-high.
REQ-006 pix_tick  in  1  one-clk pulse per pixel; 1 clk in every 2.
REQ-007 video_on  in  1  high while the current pixel is in the visible area.
REQ-008 x, y  in  10 each  current pixel coordinate from the display timing block.
REQ-009 wr_valid  in  1  game-logic tile write request.
REQ-010 wr_addr  in  13  tile index to write, range 0..MAP_W*MAP_H-1.
REQ-011 wr_data  in  8  tile code to write.
REQ-012 wr_ready  out  1  queue can accept a write this cycle.
REQ-013 ram_addr  out  13  single-port tile RAM address.
REQ-014 ram_we  out  1  tile RAM write enable.
REQ-015 ram_wdata  out  8  tile RAM write data.
REQ-016 ram_rdata  in  8  tile RAM read data, valid 1 clk after the address.
REQ-017 tile_code  out  8  tile code for the current pixel.
REQ-018 tile_valid  out  1  one-clk pulse when tile_code updates.
REQ-019 fifo_level  out  3  number of occupied queue entries, 0..FIFO_DEPTH.
REQ-020 drop_count  out  8  count of rejected out-of-range writes; saturates at 255.

Function
REQ-021 The write handshake completes on a clk edge when wr_valid=1 and wr_ready=1.
REQ-022 wr_ready shall equal (fifo_level < FIFO_DEPTH).
REQ-023 A write with wr_addr >= MAP_W*MAP_H is accepted but not queued, and drop_count increments by 1 (saturating at 255).
REQ-024 The write queue is a FIFO: queued writes reach RAM in acceptance order, with none lost or duplicated.
REQ-025 Display slot: a cycle with pix_tick=1 and video_on=1.
- ram_addr = (y>>3)*MAP_W + (x>>3); ram_we = 0.
- FSM state DISP_RD.
REQ-026 Writer slot: any non-display cycle with the FIFO non-empty.
- Pop the head entry; drive ram_addr and ram_wdata from it; ram_we = 1.
- FSM state WR.
REQ-027 Any other cycle: FSM state IDLE; ram_we = 0; ram_addr holds its previous value.
REQ-028 Display slot priority is absolute; a pending write never delays a display read.
REQ-029 Display latency:
- The clk after a DISP_RD cycle, tile_code is registered from ram_rdata.
- tile_valid = 1 for exactly that one clk.
- Total latency is 2 clk from pix_tick.
REQ-030 tile_code holds its value between updates; tile_valid = 0 outside display reads.
REQ-031 Simultaneous push and pop in one cycle leaves fifo_level unchanged.
- When full, a pop frees space only on the next cycle; wr_ready is not combinationally dependent on the pop.
REQ-032 Pointer arithmetic wraps modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH or underflows below 0.
REQ-033 Throughput: in the visible area at least every other clk is a writer slot; during blanking every clk is a writer slot.
REQ-034 A write to the tile currently being read shall not corrupt tile_code. The RAM's read-before-write behaviour is irrelevant because reads and writes never share a cycle.

Reset
REQ-035 While reset=1:
- FIFO emptied; fifo_level = 0; wr_ready = 0.
- ram_we = 0; ram_addr = 0; ram_wdata = 0.
- tile_code = 0; tile_valid = 0; drop_count = 0; FSM = IDLE.
REQ-036 Reset mid-operation discards all queued writes. No RAM write occurs in the reset cycle or the cycle after it.
REQ-037 wr_ready returns to 1 on the first clk after reset deasserts.

Verification
REQ-038 Blanking burst: video_on=0; push 4 writes (addr 0,1,2,3; data 0xA0..0xA3) back-to-back.
- Expect 4 consecutive ram_we pulses in order.
- fifo_level peaks at 1; wr_ready stays 1.
REQ-039 Full queue: video_on=1 with pix_tick every other clk; push 6 writes with no gaps.
- Expect wr_ready low whenever fifo_level = 4.
- All 6 writes land in order; no ram_we coincides with pix_tick.
REQ-040 Display address: x=17, y=9, pix_tick=1, video_on=1.
- Expect ram_addr = 82.
- Return ram_rdata = 0x5C; expect tile_code = 0x5C with tile_valid = 1 exactly 2 clk after pix_tick.
REQ-041 Range check: push addr 4800, then addr 4799.
- First write: drop_count = 1 and no RAM write.
- Second write: one ram_we with ram_addr = 4799.
- After 300 invalid pushes, drop_count = 255.
REQ-042 Reset mid-queue: fill 3 entries, then assert reset for 1 clk.
- Expect fifo_level = 0 and no ram_we for 2 clk.
- tile_code = 0; wr_ready = 1 on the following clk.
REQ-043 Push/pop collision: fifo_level = 2 during blanking, with one push in the same cycle as a pop.
- fifo_level stays 2.
- The pushed data is written after the two older entries.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one single-port tile RAM between display reads (absolute priority) and a queued game-logic write port.
// Latency: tile_code 2 clk after pix_tick; write port backpressures via wr_ready when the queue is full.

module vram_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 21,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  dat_i,
  output logic [W-1:0]  dat_o,
  output logic [LW-1:0] level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  // Guards keep the level inside 0..DEPTH even if a caller misbehaves.
  assign push_ok = push_i && (level_q < LW'(DEPTH));
  assign pop_ok  = pop_i && (level_q != '0);
  assign dat_o   = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end
endmodule

module vram_arbiter #(
  parameter int MAP_W      = 80,
  parameter int MAP_H      = 60,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        wr_valid,
  input  logic [12:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic [12:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  tile_code,
  output logic        tile_valid,
  output logic [2:0]  fifo_level,
  output logic [7:0]  drop_count
);
  localparam int          LW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [12:0] N_TILES = 13'(MAP_W * MAP_H);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DISP_RD = 2'd1,
    WR      = 2'd2
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [12:0]   ram_addr_q;
  logic [7:0]    ram_wdata_q;
  logic [7:0]    tile_code_q;
  logic          tile_valid_q;
  logic [7:0]    drop_q;

  logic [LW-1:0] level;
  logic [20:0]   head;
  logic [12:0]   disp_addr;
  logic          disp_slot;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;

  assign disp_addr = 13'(32'(y >> 3) * MAP_W + 32'(x >> 3));
  assign disp_slot = pix_tick && video_on;

  always_comb begin
    state_d = IDLE;
    if (disp_slot) begin
      state_d = DISP_RD;
    end else if (level != '0) begin
      state_d = WR;
    end
  end

  // wr_ready depends only on the registered level, so a pop frees space one cycle later.
  assign wr_ready = !reset && (level < LW'(FIFO_DEPTH));
  assign accept   = wr_valid && wr_ready;
  assign in_range = wr_addr < N_TILES;
  assign push     = accept && in_range;
  assign pop      = !reset && (state_d == WR);

  vram_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (21)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .dat_i   ({wr_addr, wr_data}),
    .dat_o   (head),
    .level_o (level)
  );

  // The RAM port is driven in the slot cycle itself so the RAM's 1-clk read
  // latency plus the tile_code register gives exactly 2 clk from pix_tick.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = ram_addr_q;
    ram_wdata = ram_wdata_q;
    if (reset) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (state_d == DISP_RD) begin
      ram_addr = disp_addr;
    end else if (state_d == WR) begin
      ram_we    = 1'b1;
      ram_addr  = head[20:8];
      ram_wdata = head[7:0];
    end
  end

  assign tile_code  = reset ? 8'h00 : tile_code_q;
  assign tile_valid = !reset && tile_valid_q;
  assign fifo_level = reset ? 3'd0 : 3'(level);
  assign drop_count = reset ? 8'h00 : drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      tile_code_q  <= '0;
      tile_valid_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      ram_addr_q   <= ram_addr;
      ram_wdata_q  <= ram_wdata;
      tile_valid_q <= (state_q == DISP_RD);
      if (state_q == DISP_RD) begin
        tile_code_q <= ram_rdata;
      end
      if (accept && !in_range && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: reference model built from queue/array behaviour, table of display vectors, corner sequences, random traffic.
module tb_vram_arbiter;
  localparam int MAP_W = 80;
  localparam int MAP_H = 60;
  localparam int FD    = 4;
  localparam int NT    = MAP_W * MAP_H;

  logic        clk = 1'b0;
  logic        reset, pix_tick, video_on, wr_valid, wr_ready, ram_we, tile_valid;
  logic [9:0]  x, y;
  logic [12:0] wr_addr, ram_addr;
  logic [7:0]  wr_data, ram_wdata, ram_rdata, tile_code, drop_count;
  logic [2:0]  fifo_level;

  vram_arbiter #(.MAP_W(MAP_W), .MAP_H(MAP_H), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .pix_tick(pix_tick), .video_on(video_on),
    .x(x), .y(y), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .tile_code(tile_code), .tile_valid(tile_valid),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  mem  [8192];   // RAM as the DUT sees it
  logic [7:0]  mmem [8192];   // RAM as the model says it should be
  logic [20:0] mq [$];
  int          m_drop, m_last_addr;
  logic [7:0]  m_tile, p1_d, p2_d;
  bit          p1_v, p2_v;

  int s_addr, s_tile, s_tv, s_level, s_drop, s_ready;
  int lvl_peak, we_cnt;

  typedef struct {
    int         x;
    int         y;
    int         exp_addr;
    logic [7:0] exp_tile;
  } dvec_t;
  dvec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_in();
    reset = 1'b0; pix_tick = 1'b0; video_on = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; x = '0; y = '0;
  endtask

  // One clock: check outputs mid-cycle against the model, advance model and RAM.
  task automatic cycle();
    int          sz, ea;
    logic [20:0] hd;
    logic [7:0]  rd_nxt;
    #4;
    cyc++;
    s_addr = ram_addr; s_tile = tile_code; s_tv = tile_valid;
    s_level = fifo_level; s_drop = drop_count; s_ready = wr_ready;
    if (fifo_level > lvl_peak) lvl_peak = fifo_level;
    if (ram_we) we_cnt++;
    if (reset) begin
      chk("rst_ready", wr_ready, 0);   chk("rst_level", fifo_level, 0);
      chk("rst_we", ram_we, 0);        chk("rst_addr", ram_addr, 0);
      chk("rst_wdata", ram_wdata, 0);  chk("rst_tile", tile_code, 0);
      chk("rst_tvalid", tile_valid, 0); chk("rst_drop", drop_count, 0);
      mq.delete(); m_drop = 0; m_last_addr = 0; m_tile = 0; p1_v = 0; p2_v = 0;
    end else begin
      sz = mq.size();
      chk("wr_ready", wr_ready, sz < FD);
      chk("fifo_level", fifo_level, sz);
      chk("drop_count", drop_count, m_drop);
      chk("tile_valid", tile_valid, p2_v);
      if (p2_v) m_tile = p2_d;
      chk("tile_code", tile_code, m_tile);
      p2_v = p1_v; p2_d = p1_d; p1_v = 0;
      if (pix_tick && video_on) begin
        ea = (int'(y) / 8) * MAP_W + int'(x) / 8;
        chk("disp_we", ram_we, 0);
        chk("disp_addr", ram_addr, ea);
        p1_v = 1; p1_d = mmem[ea]; m_last_addr = ea;
      end else if (sz > 0) begin
        hd = mq.pop_front();
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, hd[20:8]);
        chk("wr_data", ram_wdata, hd[7:0]);
        mmem[hd[20:8]] = hd[7:0]; m_last_addr = hd[20:8];
      end else begin
        chk("idle_we", ram_we, 0);
        chk("idle_addr", ram_addr, m_last_addr);
      end
      if (wr_valid && sz < FD) begin
        if (int'(wr_addr) >= NT) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        else mq.push_back({wr_addr, wr_data});
      end
    end
    rd_nxt = mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
    @(posedge clk);
    #1;
    ram_rdata = rd_nxt;
  endtask

  initial begin
    tbl[0] = '{17, 9, 82, 8'h5C};
    tbl[1] = '{0, 0, 0, 8'h11};
    tbl[2] = '{639, 479, 4799, 8'hE7};
    tbl[3] = '{8, 8, 81, 8'h3A};
    tbl[4] = '{320, 240, 2440, 8'h96};
    tbl[5] = '{15, 7, 1, 8'h42};
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'(i * 37 + 5);
      mmem[i] = mem[i];
    end
    for (int i = 0; i < 6; i++) begin
      mem[tbl[i].exp_addr] = tbl[i].exp_tile;
      mmem[tbl[i].exp_addr] = tbl[i].exp_tile;
    end
    idle_in();
    reset = 1'b1; ram_rdata = '0;
    m_drop = 0; m_last_addr = 0; m_tile = 0; p1_v = 0; p2_v = 0; p1_d = 0; p2_d = 0;
    lvl_peak = 0; we_cnt = 0;
    @(posedge clk);
    #1;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("release_ready", s_ready, 1);

    // Display address/latency table
    for (int i = 0; i < 6; i++) begin
      pix_tick = 1'b1; video_on = 1'b1;
      x = 10'(tbl[i].x); y = 10'(tbl[i].y);
      cycle();
      chk("tbl_addr", s_addr, tbl[i].exp_addr);
      pix_tick = 1'b0;
      cycle(); cycle();
      chk("tbl_tile", s_tile, tbl[i].exp_tile);
      chk("tbl_tvalid", s_tv, 1);
      cycle();
      chk("tbl_tile_hold", s_tile, tbl[i].exp_tile);
    end

    // Blanking burst
    idle_in(); lvl_peak = 0; we_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(k); wr_data = 8'(8'hA0 + k);
      cycle();
    end
    wr_valid = 1'b0;
    repeat (3) cycle();
    chk("burst_peak", lvl_peak, 1);
    chk("burst_we", we_cnt, 4);

    // Visible area, pix_tick every other clk, 6 writes
    idle_in(); video_on = 1'b1; we_cnt = 0;
    begin
      int k = 0;
      for (int t = 0; t < 40; t++) begin
        pix_tick = (t % 2 == 0);
        x = 10'((t * 8) % 640); y = 10'(t);
        wr_valid = (k < 6); wr_addr = 13'(100 + k); wr_data = 8'(8'h50 + k);
        if (wr_valid && mq.size() < FD) k++;
        cycle();
      end
      chk("vis_pushed", k, 6);
    end
    chk("vis_we", we_cnt, 6);

    // Back-to-back display slots fill the queue
    idle_in(); video_on = 1'b1; pix_tick = 1'b1; x = 10'd40; y = 10'd16;
    for (int k = 0; k < 6; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(300 + k); wr_data = 8'(8'hC0 + k);
      cycle();
    end
    chk("full_level", s_level, 4);
    chk("full_ready", s_ready, 0);
    pix_tick = 1'b0;
    cycle();
    chk("full_pop_ready", s_ready, 0);
    cycle();
    chk("after_pop_ready", s_ready, 1);
    idle_in();
    repeat (6) cycle();

    // Range check and drop saturation
    idle_in(); we_cnt = 0;
    wr_valid = 1'b1; wr_addr = 13'd4800; wr_data = 8'h99;
    cycle();
    wr_valid = 1'b0;
    cycle();
    chk("drop_one", s_drop, 1);
    chk("drop_no_we", we_cnt, 0);
    wr_valid = 1'b1; wr_addr = 13'd4799; wr_data = 8'h77;
    cycle();
    wr_valid = 1'b0;
    cycle();
    chk("valid_we", we_cnt, 1);
    chk("valid_addr", s_addr, 4799);
    for (int k = 0; k < 300; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(4800 + (k % 300)); wr_data = 8'(k);
      cycle();
    end
    wr_valid = 1'b0;
    cycle();
    chk("drop_sat", s_drop, 255);

    // Reset with 3 queued entries
    idle_in(); video_on = 1'b1; pix_tick = 1'b1; x = 10'd17; y = 10'd9;
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(500 + k); wr_data = 8'(8'h30 + k);
      cycle();
    end
    idle_in(); reset = 1'b1; we_cnt = 0;
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_q_ready", s_ready, 1);
    chk("rst_q_tile", s_tile, 0);
    chk("rst_q_level", s_level, 0);
    cycle();
    chk("rst_q_no_we", we_cnt, 0);

    // Push/pop collision at level 2 in blanking
    idle_in(); video_on = 1'b1; pix_tick = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1; wr_addr = 13'(200 + k); wr_data = 8'(8'hD0 + k);
      cycle();
    end
    video_on = 1'b0; pix_tick = 1'b0;
    wr_addr = 13'd202; wr_data = 8'hD2;
    cycle();
    chk("coll_level_before", s_level, 2);
    wr_valid = 1'b0;
    cycle();
    chk("coll_level_after", s_level, 2);
    repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int mode;
      mode = (i / 500) % 3;
      reset    = ($urandom_range(299) == 0);
      video_on = (mode != 0);
      pix_tick = (mode == 2) ? ($urandom_range(3) != 0) : (i % 2 == 0);
      x = 10'($urandom_range(639)); y = 10'($urandom_range(479));
      wr_valid = $urandom_range(1) == 1;
      wr_addr  = ($urandom_range(9) == 0) ? 13'(4800 + $urandom_range(3391)) : 13'($urandom_range(4799));
      wr_data  = 8'($urandom);
      cycle();
    end
    idle_in();
    repeat (8) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
